// File: rtl/mul8_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mul8_seq (with helper add8)                                 |
// | Purpose  : 8x8 unsigned shift-add multiplier, one add8 + shift/clock.  |
// | Option   : MUL8_ZERO_SKIP_EN - zero operand completes at accept edge.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+

module add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

module mul8_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);
    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [7:0]  r_mcand;
    // Working register {hi, lo}; the carry bit is consumed by the shift in
    // the same cycle, so it never needs its own flop.
    logic [15:0] r_p;
    logic [3:0]  r_count;
    logic [15:0] r_product;
    logic [7:0]  w_sum;
    logic        w_carry;
    logic [15:0] w_p_next;
    logic        w_zero;

    add8 u_add8 (
        .a    (r_p[15:8]),
        .b    (r_mcand),
        .cin  (1'b0),
        .s    (w_sum),
        .cout (w_carry)
    );

    // Carry out of the adder lands in bit 15 after the shift.
    assign w_p_next = r_p[0] ? {w_carry, w_sum, r_p[7:1]}
                             : {1'b0, r_p[15:1]};

`ifdef MUL8_ZERO_SKIP_EN
    assign w_zero = (a == 8'd0) || (b == 8'd0);
`else
    assign w_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_IDLE: begin
                if (start) begin
                    w_state_next = w_zero ? C_DONE : C_RUN;
                end
            end
            C_RUN: begin
                if (r_count == 4'd7) begin
                    w_state_next = C_DONE;
                end
            end
            C_DONE:  w_state_next = C_IDLE;
            default: w_state_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand   <= 8'd0;
            r_p       <= 16'd0;
            r_count   <= 4'd0;
            r_product <= 16'd0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (start) begin
                        r_mcand <= a;
                        r_p     <= {8'd0, b};
                        r_count <= 4'd0;
                        if (w_zero) begin
                            r_product <= 16'd0;
                        end
                    end
                end
                C_RUN: begin
                    r_p     <= w_p_next;
                    r_count <= r_count + 4'd1;
                    if (r_count == 4'd7) begin
                        r_product <= w_p_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (r_state == C_RUN);
    assign done    = (r_state == C_DONE);
    assign product = r_product;
endmodule

`default_nettype wire

// File: tb/tb_mul8_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_mul8_seq                                                 |
// | Purpose  : Self-checking bench for mul8_seq (vector table + random).   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+

module tb_mul8_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul8_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  a_post;
        logic [7:0]  b_post;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_product(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = int'(x) * int'(y);
        return p[15:0];
    endfunction

    function automatic int ref_latency(input logic [7:0] x, input logic [7:0] y);
`ifdef MUL8_ZERO_SKIP_EN
        return (x == 8'd0 || y == 8'd0) ? 0 : 8;
`else
        if (x == 8'd0 && y == 8'd0) return 8;
        return 8;
`endif
    endfunction

    // Start one multiply; operands switch to (pa, pb) two cycles after accept.
    task automatic run_mul(input logic [7:0] ta, input logic [7:0] tb2,
                           input logic [7:0] pa, input logic [7:0] pb,
                           input logic [15:0] exp_p, input string name);
        int lat;
        bit busy_ok;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb2;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (lat == 2) begin
                a = pa;
                b = pb;
            end
        end
        chk({name, " latency"}, lat, ref_latency(ta, tb2));
        chk({name, " busy during run"}, {31'd0, busy_ok}, 32'd1);
        chk({name, " product"}, {16'd0, product}, {16'd0, exp_p});
        chk({name, " busy at done"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, " done one cycle"}, {31'd0, done}, 32'd0);
        chk({name, " product hold"}, {16'd0, product}, {16'd0, exp_p});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done;
        int second_done;
        int n_done;
        int conflicts;
        logic busy9;
        logic busy10;
        logic [7:0] x;
        logic [7:0] y;

        vecs[0] = '{8'd13,  8'd11,  8'd13,  8'd11,  16'd143,   "basic"};
        vecs[1] = '{8'd255, 8'd255, 8'd255, 8'd255, 16'hFE01,  "carry_ff"};
        vecs[2] = '{8'd200, 8'd2,   8'd200, 8'd2,   16'd400,   "carry_200x2"};
        vecs[3] = '{8'd0,   8'd200, 8'd0,   8'd200, 16'd0,     "zero_a"};
        vecs[4] = '{8'd9,   8'd9,   8'd7,   8'd7,   16'd81,    "operand_change"};
        vecs[5] = '{8'd1,   8'd255, 8'd0,   8'd0,   16'd255,   "one_x_ff"};
        vecs[6] = '{8'd128, 8'd255, 8'd3,   8'd4,   16'd32640, "msb_carry"};

        reset = 1'b1;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset product", {16'd0, product}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_mul(vecs[i].a, vecs[i].b, vecs[i].a_post, vecs[i].b_post,
                    vecs[i].exp, vecs[i].name);
        end

        // Start held high for 20 cycles: accepts at edges 0 and 10 only.
        @(negedge clk);
        start       = 1'b1;
        a           = 8'd3;
        b           = 8'd5;
        n_done      = 0;
        first_done  = -1;
        second_done = -1;
        conflicts   = 0;
        busy9       = 1'b1;
        busy10      = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            if (i == 19) start = 1'b0;
            if (i == 9)  busy9 = busy;
            if (i == 10) busy10 = busy;
            if (busy === 1'b1 && done === 1'b1) conflicts++;
            if (done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
        end
        chk("held first done", first_done, 8);
        chk("held second done", second_done, 18);
        chk("held done count", n_done, 2);
        chk("held idle gap busy", {31'd0, busy9}, 32'd0);
        chk("held reaccept busy", {31'd0, busy10}, 32'd1);
        chk("held busy/done overlap", conflicts, 0);
        chk("held product", {16'd0, product}, 32'd15);

        // Asynchronous reset during the fourth iteration of 100x100.
        @(negedge clk);
        start = 1'b1;
        a     = 8'd100;
        b     = 8'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrun reset busy", {31'd0, busy}, 32'd0);
        chk("midrun reset done", {31'd0, done}, 32'd0);
        chk("midrun reset product", {16'd0, product}, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        chk("no activity after reset", n_done, 0);
        run_mul(8'd6, 8'd7, 8'd6, 8'd7, 16'd42, "after_reset");

        for (int i = 0; i < 30; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            if ($urandom_range(0, 7) == 0) x = 8'd0;
            if ($urandom_range(0, 7) == 0) y = 8'd0;
            run_mul(x, y, 8'($urandom), 8'($urandom), ref_product(x, y), "random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
